// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary R x C systolic D = A x B with run-time K and back-pressured row drain.
// Optional macro SYSMM_SAT_EN: saturating accumulators plus a sticky sat_flag output.
module systolic_mm_engine #(
    parameter int N  = 8,
    parameter int M  = 20,
    parameter int R  = 4,
    parameter int C  = 4,
    parameter int LW = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [LW-1:0]                    klen,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [R*N-1:0]                   a_col,
    input  logic [C*N-1:0]                   b_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [C*M-1:0]                   out_data,
    output logic [(R>1?$clog2(R):1)-1:0]     out_row,
`ifdef SYSMM_SAT_EN
    output logic                             sat_flag,
`endif
    output logic                             busy,
    output logic                             done
);
    localparam int RW = R > 1 ? $clog2(R) : 1;
    localparam int FW = $clog2(R + C);
`ifdef SYSMM_SAT_EN
    localparam int SW = M + 1;
`else
    localparam int SW = M;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
    state_t state;
    logic [LW-1:0] klen_q, kcnt;
    logic [FW-1:0] fcnt;
    logic beat, acc_clr, acc_en;
    logic [N-1:0] a_bus [R][C+1];
    logic [N-1:0] b_bus [R+1][C];
    logic [M-1:0] acc_v [R][C];

    assign beat    = in_valid & in_ready;
    assign acc_clr = (state == IDLE) & start;
    assign acc_en  = (state == LOAD) | (state == FLUSH);
    assign done    = out_valid & out_ready & (out_row == RW'(R - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_row   <= '0;
            klen_q    <= '0;
            kcnt      <= '0;
            fcnt      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    klen_q    <= klen;
                    kcnt      <= '0;
                    busy      <= 1'b1;
                    out_row   <= '0;
                    in_ready  <= klen != '0;
                    out_valid <= klen == '0;
                    state     <= klen != '0 ? LOAD : DRAIN;
                end
                LOAD: if (beat) begin
                    kcnt <= kcnt + LW'(1);
                    if (kcnt == klen_q - LW'(1)) begin
                        in_ready <= 1'b0;
                        fcnt     <= '0;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == FW'(R + C - 2)) begin
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                default: if (out_ready) begin
                    if (out_row == RW'(R - 1)) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_row   <= '0;
                        state     <= IDLE;
                    end else begin
                        out_row <= out_row + RW'(1);
                    end
                end
            endcase
        end
    end

    // Row i of A is delayed i cycles so that k-slices meet diagonally in the array.
    for (genvar i = 0; i < R; i++) begin : g_ask
        logic [N-1:0] a_in;
        assign a_in = beat ? a_col[i*N +: N] : '0;
        if (i == 0) begin : g_d
            assign a_bus[i][0] = a_in;
        end else begin : g_d
            logic [N-1:0] dl [i];
            always_ff @(posedge clk) begin
                for (int d = 0; d < i; d++) dl[d] <= !rst ? '0 : (d == 0 ? a_in : dl[d > 0 ? d - 1 : 0]);
            end
            assign a_bus[i][0] = dl[i-1];
        end
    end

    for (genvar j = 0; j < C; j++) begin : g_bsk
        logic [N-1:0] b_in;
        assign b_in = beat ? b_row[j*N +: N] : '0;
        if (j == 0) begin : g_d
            assign b_bus[0][j] = b_in;
        end else begin : g_d
            logic [N-1:0] dl [j];
            always_ff @(posedge clk) begin
                for (int d = 0; d < j; d++) dl[d] <= !rst ? '0 : (d == 0 ? b_in : dl[d > 0 ? d - 1 : 0]);
            end
            assign b_bus[0][j] = dl[j-1];
        end
        assign out_data[j*M +: M] = acc_v[out_row][j];
    end

`ifdef SYSMM_SAT_EN
    logic [R*C-1:0] ovf;
    always_ff @(posedge clk) begin
        sat_flag <= !rst ? 1'b0 : acc_clr ? 1'b0 : (sat_flag | (|ovf));
    end
`endif

    for (genvar i = 0; i < R; i++) begin : g_r
        for (genvar j = 0; j < C; j++) begin : g_c
            logic [N-1:0] a_q, b_q;
            logic [M-1:0] acc_q, nxt;
            logic [SW-1:0] sum;
            assign sum = SW'(acc_q) + SW'(a_bus[i][j]) * SW'(b_bus[i][j]);
`ifdef SYSMM_SAT_EN
            assign nxt = sum[M] ? '1 : sum[M-1:0];
            assign ovf[i*C+j] = acc_en & sum[M];
`else
            assign nxt = sum;
`endif
            always_ff @(posedge clk) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_bus[i][j];
                    b_q   <= b_bus[i][j];
                    acc_q <= acc_clr ? '0 : acc_en ? nxt : acc_q;
                end
            end
            assign a_bus[i][j+1] = a_q;
            assign b_bus[i+1][j] = b_q;
            assign acc_v[i][j]   = acc_q;
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: random and directed jobs against a matrix-product reference model with a scoreboard.
module tb_systolic_mm_engine;
    localparam int N = 8, M = 20, R = 4, C = 4, LW = 8, RW = 2, KMAX = 32;

    logic clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 1;
    logic [LW-1:0] klen = 0;
    logic [R*N-1:0] a_col = 0;
    logic [C*N-1:0] b_row = 0;
    logic in_ready, out_valid, busy, done;
    logic [C*M-1:0] out_data;
    logic [RW-1:0] out_row;
`ifdef SYSMM_SAT_EN
    logic sat_flag;
`endif

    systolic_mm_engine #(.N(N), .M(M), .R(R), .C(C), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .klen(klen), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row),
`ifdef SYSMM_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {logic [C*M-1:0] data; int row;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0, hold = 0;
    bit bp = 0, ir_seen = 0;
    int am [R][KMAX];
    int bm [KMAX][C];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (hold > 0) begin
            out_ready = 0;
            hold--;
        end else out_ready = bp ? 1'($urandom % 2) : 1'b1;
    end

    // Every valid cycle must show the head of the expected queue, stalled or not.
    always @(negedge clk) if (rst) begin
        if (in_ready) ir_seen = 1;
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row got row %0d data %h, required no output", out_row, out_data);
            end else begin
                if (out_data !== exp_q[0].data || out_row !== RW'(exp_q[0].row)) begin
                    errors++;
                    $display("FAIL row_data got row %0d data %h, required row %0d data %h",
                             out_row, out_data, exp_q[0].row, exp_q[0].data);
                end
                checks++;
                if (done !== (out_ready && exp_q[0].row == R - 1)) begin
                    errors++;
                    $display("FAIL done_pulse got %b on row %0d", done, exp_q[0].row);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end else if (done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL done_idle got %b, required 0", done);
        end
    end

    task automatic chk(input bit ok, input string name, input longint got, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < R; r++) for (int k = 0; k < KMAX; k++) am[r][k] = mode ? 255 : int'($urandom % 256);
        for (int k = 0; k < KMAX; k++) for (int c = 0; c < C; c++) bm[k][c] = mode ? 255 : int'($urandom % 256);
    endtask

    task automatic push_expected(input int k);
        exp_t e;
        for (int r = 0; r < R; r++) begin
            e.row = r;
            for (int c = 0; c < C; c++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(am[r][kk]) * bm[kk][c];
`ifdef SYSMM_SAT_EN
                if (s > (longint'(1) << M) - 1) s = (longint'(1) << M) - 1;
`else
                s = s % (longint'(1) << M);
`endif
                e.data[c*M +: M] = M'(s);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_job(input int k, input bit bubble, input bit stress, input int hold_n);
        int idx = 0, t = 0, st_cyc;
        bit take;
        push_expected(k);
        ir_seen = 0;
        start = 1;
        klen = LW'(k);
        st_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        while (idx < k && t < 500) begin
            in_valid = bubble ? 1'($urandom % 2) : 1'b1;
            for (int i = 0; i < R; i++) a_col[i*N +: N] = in_valid ? N'(am[i][idx]) : N'($urandom);
            for (int j = 0; j < C; j++) b_row[j*N +: N] = in_valid ? N'(bm[idx][j]) : N'($urandom);
            if (stress) begin
                start = 1'($urandom % 2);
                klen = LW'($urandom);
            end
            take = in_valid & in_ready;
            @(posedge clk); #1;
            t++;
            if (take) idx++;
        end
        in_valid = 0;
        start = 0;
        chk(idx == k, "beats_accepted", idx, k);
        if (k > 0) chk(in_ready == 0, "ready_after_last_beat", in_ready, 0);
        while (!out_valid && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (k > 0 && !bubble && !stress) chk(cyc - st_cyc == k + R + C, "first_valid_latency", cyc - st_cyc, k + R + C);
        hold = hold_n;
        while (busy && t < 1500) begin
            start = stress;
            @(posedge clk); #1;
            t++;
        end
        start = 0;
        chk(busy == 0, "job_completes", busy, 0);
        @(posedge clk); #1;
        chk(busy == 0 && out_valid == 0, "idle_after_done", {busy, out_valid}, 0);
        chk(exp_q.size() == 0, "rows_delivered", R - exp_q.size(), R);
        if (k == 0) chk(ir_seen == 0, "klen0_no_ready", ir_seen, 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk(busy == 0 && in_ready == 0 && out_valid == 0 && done == 0, "reset_flags", {busy, in_ready, out_valid, done}, 0);
        chk(out_row == 0 && out_data == 0, "reset_output", out_data, 0);
        rst = 1;
        @(posedge clk); #1;
        fill(1);
        run_job(4, 0, 0, 0);
        run_job(20, 0, 0, 0);
        fill(0);
        run_job(2, 1, 1, 0);
        run_job(0, 0, 1, 0);
        bp = 1;
        run_job(7, 1, 0, 5);
        bp = 0;
        fill(0);
        start = 1;
        klen = 5;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        in_valid = 0;
        @(posedge clk); #1;
        chk(busy == 0 && out_valid == 0 && in_ready == 0 && out_row == 0, "abort_reset", {busy, out_valid, in_ready}, 0);
        rst = 1;
        @(posedge clk); #1;
        chk(out_valid == 0, "abort_no_output", out_valid, 0);
        run_job(1, 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            fill(0);
            bp = 1'($urandom % 2);
            run_job(int'($urandom_range(0, 20)), 1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Output-stationary R x C systolic matrix multiplier computing D = A x B, where A is R x K and B is K x C.
- The inner dimension K is programmable at run time.
- Internal skew registers, a control FSM and a back-pressured row-serial result drain are all built in.
- Successor to the fixed square systolic array: operands stream in unskewed, one k-slice per beat, with start/done control. Sits between the operand buffers and the result store.

Parameters:
- N, 8: operand width (unsigned, per element).
- M, 20: accumulator and result element width. M >= 2*N.
- R, 4: array rows (rows of A and D).
- C, 4: array columns (columns of B and D).
- LW, 8: width of the klen field. K ranges 0..2^LW-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse to begin a job; sampled only in IDLE.
- klen  in  LW  inner dimension K; captured when start is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts an operand beat.
- a_col  in  R*N  column k of A. Element i sits at [(i+1)*N-1 : i*N].
- b_row  in  C*N  row k of B. Element j sits at [(j+1)*N-1 : j*N].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the result row.
- out_data  out  C*M  row r of D. Element j sits at [(j+1)*M-1 : j*M].
- out_row  out  clog2(R) (min 1)  index r of the current out_data row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on acceptance of the last result row.

Behaviour:
- Reset (rst=0 at a clock edge) has these effects:
  - FSM goes to IDLE.
  - All accumulators, skew registers and PE pipeline registers clear to 0.
  - in_ready, out_valid, busy and done are all 0; out_row = 0; out_data = 0.
  - Reset mid-job aborts the job; no partial output is produced.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 captures klen, clears all accumulators, and sets busy=1 next cycle.
  - Next state is LOAD if klen != 0, otherwise DRAIN.
- LOAD:
  - in_ready=1.
  - A beat is counted when in_valid & in_ready.
  - The array shifts every cycle.
  - With no valid beat, zeros are injected into both skew paths. Bubbles are therefore harmless and alignment is preserved.
- Skew:
  - a_col element i enters a delay line of i registers before PE(i,0).
  - b_row element j enters a delay line of j registers before PE(0,j).
  - A values move right one PE per cycle; B values move down one PE per cycle.
  - Each PE computes acc <= acc + a*b every cycle (registered MAC).
- LOAD -> FLUSH occurs on the cycle the klen-th beat is accepted. in_ready=0 from the next cycle.
- FLUSH:
  - Runs exactly R+C-1 cycles, injecting zeros.
  - Then moves to DRAIN; every accumulator is final at that point.
- DRAIN:
  - out_valid=1 and out_data = accumulator row out_row, starting at out_row=0.
  - On out_valid & out_ready, out_row increments.
  - While out_ready=0, out_data and out_row are held stable.
  - Acceptance of row R-1 pulses done for that cycle and returns the FSM to IDLE; out_valid=0 next cycle.
- Accumulators are frozen outside LOAD and FLUSH.
- Arithmetic:
  - Products are unsigned and 2N bits wide, zero-extended to M.
  - Accumulation wraps modulo 2^M unless the optional feature is enabled.
- Boundary cases:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored; no beat is consumed.
  - klen=0 produces R rows of zeros.
  - start and done coincide only across IDLE; a start in the same cycle as done is ignored.
  - The minimum job latency from start to first out_valid is 1 + K + (R+C-1) cycles, given in_valid held high.

Optional Feature:
- Macro: SYSMM_SAT_EN.
- Defined: each PE accumulator saturates at 2^M-1 and stays there for the rest of the job. A sticky output sat_flag (1 bit, reset 0, cleared on start acceptance) goes high if any PE saturated; it is valid during DRAIN.
- Undefined: accumulators wrap modulo 2^M, and the sat_flag port does not exist.

Test Plan:
- R=C=2, N=8, K=2, A=[[1,2],[3,4]], B=identity, out_ready=1 -> row0=[1,2], row1=[3,4]; done pulses on row1; first out_valid 6 cycles after start.
- R=C=4, K=4, A=B=all 255 -> every D element = 4*65025 = 260100, with no wrap at M=20.
- Bubble insertion: the same operands as case 1 with in_valid toggling 1,0,0,1 -> identical results; FLUSH starts only after the 2nd accepted beat.
- Backpressure: out_ready low for 5 cycles in DRAIN -> out_data and out_row held; each row is delivered exactly once, in order 0..R-1.
- klen=0 -> R zero rows with no in_ready assertion. A start during busy is ignored, and the job completes unchanged.
- Reset mid-LOAD (rst=0 for one cycle) -> busy=0 and out_valid=0. A new job with K=1, a=[2,3], b=[5,7] yields [[10,14],[15,21]]. With SYSMM_SAT_EN and M=16, K=2, all 255 -> 65535 and sat_flag=1.
